// File: rtl/camera_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : camera_spi_pkg
// Description : Shared opcodes, read-path state type, status bit positions
//               and the zoom clamp helper for the camera SPI register block.
// Revision    : 1.0 - initial release
// ============================================================================
package camera_spi_pkg;

  localparam logic [7:0] OP_CAPTURE     = 8'h20;
  localparam logic [7:0] OP_BYTES_AVAIL = 8'h21;
  localparam logic [7:0] OP_READ_DATA   = 8'h22;
  localparam logic [7:0] OP_ZOOM        = 8'h23;
  localparam logic [7:0] OP_METERING    = 8'h25;
  localparam logic [7:0] OP_COMPRESSION = 8'h26;
  localparam logic [7:0] OP_STATUS      = 8'h27;
  localparam logic [7:0] OP_POWER_SAVE  = 8'h28;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    STREAM   = 2'd2
  } read_state_t;

  localparam int STATUS_READY_BIT    = 0;
  localparam int STATUS_BUSY_BIT     = 1;
  localparam int STATUS_REJECTED_BIT = 2;

  // Limit a requested resolution to the legal window [lo, hi].
  function automatic logic [15:0] clamp16(input logic [15:0] v,
                                          input logic [15:0] lo,
                                          input logic [15:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_edge_monitor.sv
`default_nettype none
// ============================================================================
// Module      : spi_edge_monitor
// Description : Two-flop history register producing single-cycle rise and
//               fall indications for each bit of the monitored input.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_edge_monitor #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] sig_i,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] stage1_q;
  logic [WIDTH-1:0] stage2_q;

  // Keep the two most recent samples of the input.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= sig_i;
      stage2_q <= stage1_q;
    end
  end

  assign rise_o = stage1_q & ~stage2_q;
  assign fall_o = ~stage1_q & stage2_q;

endmodule
`default_nettype wire

// File: rtl/spi_camera_registers_multi.sv
`default_nettype none
// ============================================================================
// Module      : spi_camera_registers_multi
// Description : Decodes camera opcodes from the SPI target into control
//               outputs, status/metering readback and prefetched image
//               buffer streaming.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_camera_registers_multi
  import camera_spi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int RES_WIDTH      = 10,
  parameter int RES_MIN        = 100,
  parameter int RES_MAX        = 720,
  parameter int RES_DEFAULT    = 360,
  parameter int METER_CHANNELS = 6,
  parameter int READ_LATENCY   = 1
) (
  input  logic                        clock_in,
  input  logic                        reset_n_in,
  input  logic [7:0]                  op_code_in,
  input  logic                        op_code_valid_in,
  input  logic [7:0]                  operand_in,
  input  logic                        operand_valid_in,
  input  logic [7:0]                  operand_count_in,
  output logic [7:0]                  response_out,
  output logic                        response_valid_out,
  output logic                        start_capture_out,
  output logic [RES_WIDTH-1:0]        half_resolution_out,
  output logic [1:0]                  compression_factor_out,
  output logic                        power_save_enable_out,
  input  logic                        image_ready_in,
  input  logic [ADDR_WIDTH-1:0]       image_total_size_in,
  input  logic [7:0]                  image_data_in,
  output logic [ADDR_WIDTH-1:0]       image_address_out,
  input  logic [8*METER_CHANNELS-1:0] metering_in
);

  localparam int NB = ADDR_WIDTH / 8;

  // Edge indications
  logic op_rise, op_fall, opnd_rise, opnd_fall, rdy_rise, rdy_fall;
  logic unused_falls;

  // Control state
  logic [7:0]           op_q;
  logic                 busy_q;
  logic                 rejected_q;
  logic                 start_capture_q;
  logic [15:0]          zoom_shadow_q;
  logic [RES_WIDTH-1:0] half_res_q;
  logic [1:0]           compression_q;
  logic                 power_save_q;

  // Read path state
  read_state_t          rd_state_q;
  logic [1:0]           wait_q;
  logic [7:0]           hold_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  // Response path
  logic [7:0]           response_d, response_q;
  logic                 response_valid_d, response_valid_q;
  logic [7:0]           status_byte;
  logic [ADDR_WIDTH-1:0] remaining;
  logic [RES_WIDTH-1:0] zoom_clamped;

  logic capture_go, capture_rej, operand_wr;

  spi_edge_monitor #(.WIDTH(1)) u_op_mon (
    .clk_i(clock_in), .rst_n_i(reset_n_in), .sig_i(op_code_valid_in),
    .rise_o(op_rise), .fall_o(op_fall)
  );

  spi_edge_monitor #(.WIDTH(1)) u_operand_mon (
    .clk_i(clock_in), .rst_n_i(reset_n_in), .sig_i(operand_valid_in),
    .rise_o(opnd_rise), .fall_o(opnd_fall)
  );

  spi_edge_monitor #(.WIDTH(1)) u_ready_mon (
    .clk_i(clock_in), .rst_n_i(reset_n_in), .sig_i(image_ready_in),
    .rise_o(rdy_rise), .fall_o(rdy_fall)
  );

  assign unused_falls = opnd_fall | rdy_fall;

  assign capture_go  = op_rise && (op_code_in == OP_CAPTURE) && !busy_q;
  assign capture_rej = op_rise && (op_code_in == OP_CAPTURE) && busy_q;
  assign operand_wr  = opnd_rise && op_code_valid_in;

  assign remaining = (image_total_size_in > addr_q) ? (image_total_size_in - addr_q) : '0;

  assign zoom_clamped = RES_WIDTH'(clamp16(16'(zoom_shadow_q[RES_WIDTH-1:0]),
                                           16'(RES_MIN), 16'(RES_MAX)));

  // Assemble the status byte from the busy/rejected flags and live ready level.
  always_comb begin
    status_byte                      = '0;
    status_byte[STATUS_READY_BIT]    = image_ready_in;
    status_byte[STATUS_BUSY_BIT]     = busy_q;
    status_byte[STATUS_REJECTED_BIT] = rejected_q;
  end

  // Capture lock, zoom shadow/commit and simple control registers.
  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      op_q            <= '0;
      busy_q          <= 1'b0;
      rejected_q      <= 1'b0;
      start_capture_q <= 1'b0;
      zoom_shadow_q   <= 16'(RES_DEFAULT);
      half_res_q      <= RES_WIDTH'(RES_DEFAULT);
      compression_q   <= '0;
      power_save_q    <= 1'b0;
    end else begin
      start_capture_q <= capture_go;
      if (op_rise) op_q <= op_code_in;

      // A new capture outranks a simultaneous ready rise.
      if (capture_go)    busy_q <= 1'b1;
      else if (rdy_rise) busy_q <= 1'b0;

      // A rejection outranks the clear-on-read of the status opcode.
      if (capture_rej)                           rejected_q <= 1'b1;
      else if (op_fall && (op_q == OP_STATUS))   rejected_q <= 1'b0;

      if (operand_wr) begin
        if (op_code_in == OP_ZOOM) begin
          if (operand_count_in == 8'd0)      zoom_shadow_q[15:8] <= operand_in;
          else if (operand_count_in == 8'd1) zoom_shadow_q[7:0]  <= operand_in;
        end
        if (op_code_in == OP_COMPRESSION) compression_q <= operand_in[1:0];
        if (op_code_in == OP_POWER_SAVE)  power_save_q  <= operand_in[0];
      end

      if (op_fall && (op_q == OP_ZOOM)) half_res_q <= zoom_clamped;
    end
  end

  // Image read FSM: prefetch over the buffer latency, then stream held bytes.
  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      rd_state_q <= IDLE;
      wait_q     <= '0;
      hold_q     <= '0;
      addr_q     <= '0;
    end else begin
      if (capture_go) addr_q <= '0;
      case (rd_state_q)
        IDLE: begin
          if (op_rise && (op_code_in == OP_READ_DATA)) begin
            rd_state_q <= PREFETCH;
            wait_q     <= '0;
          end
        end
        PREFETCH: begin
          // Data for the current address is visible one cycle after the
          // buffer's final pipeline stage loads it.
          if (wait_q == 2'(READ_LATENCY)) begin
            hold_q     <= image_data_in;
            rd_state_q <= STREAM;
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end
        STREAM: begin
          if (opnd_rise && (addr_q < image_total_size_in)) begin
            addr_q     <= addr_q + ADDR_WIDTH'(1);
            rd_state_q <= PREFETCH;
            wait_q     <= '0;
          end
        end
        default: rd_state_q <= IDLE;
      endcase
      if (op_fall) rd_state_q <= IDLE;
    end
  end

  // Select the response byte for the opcode currently on the bus.
  always_comb begin
    response_d       = '0;
    response_valid_d = 1'b0;
    if (op_code_valid_in) begin
      case (op_code_in)
        OP_BYTES_AVAIL: begin
          response_valid_d = 1'b1;
          for (int j = 0; j < NB; j++) begin
            if (operand_count_in == 8'(NB - 1 - j)) response_d = remaining[8*j +: 8];
          end
        end
        OP_READ_DATA: begin
          response_valid_d = (rd_state_q == STREAM);
          response_d       = hold_q;
        end
        OP_METERING: begin
          response_valid_d = 1'b1;
          for (int k = 0; k < METER_CHANNELS; k++) begin
            if (operand_count_in == 8'(k)) response_d = metering_in[8*k +: 8];
          end
        end
        OP_STATUS: begin
          response_valid_d = 1'b1;
          response_d       = status_byte;
        end
        default: ;
      endcase
    end
  end

  // Register the response toward the SPI target.
  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      response_q       <= '0;
      response_valid_q <= 1'b0;
    end else begin
      response_q       <= response_d;
      response_valid_q <= response_valid_d;
    end
  end

  assign response_out           = response_q;
  assign response_valid_out     = response_valid_q;
  assign start_capture_out      = start_capture_q;
  assign half_resolution_out    = half_res_q;
  assign compression_factor_out = compression_q;
  assign power_save_enable_out  = power_save_q;
  assign image_address_out      = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_camera_registers_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_camera_registers_multi
// Description : Directed self-checking bench for spi_camera_registers_multi
//               with a behavioural register model and a per-cycle monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_camera_registers_multi;

  localparam int AW = 16;
  localparam int RW = 10;
  localparam int MC = 3;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          reset_n_in = 1'b0;
  logic [7:0]    op_code_in = '0;
  logic          op_code_valid_in = 1'b0;
  logic [7:0]    operand_in = '0;
  logic          operand_valid_in = 1'b0;
  logic [7:0]    operand_count_in = '0;
  logic [7:0]    response_out;
  logic          response_valid_out;
  logic          start_capture_out;
  logic [RW-1:0] half_resolution_out;
  logic [1:0]    compression_factor_out;
  logic          power_save_enable_out;
  logic          image_ready_in = 1'b0;
  logic [AW-1:0] image_total_size_in = '0;
  logic [7:0]    image_data_in;
  logic [AW-1:0] image_address_out;
  logic [8*MC-1:0] metering_in = 24'h33_22_11;

  spi_camera_registers_multi #(
    .ADDR_WIDTH(AW), .RES_WIDTH(RW), .RES_MIN(100), .RES_MAX(720),
    .RES_DEFAULT(360), .METER_CHANNELS(MC), .READ_LATENCY(RL)
  ) dut (
    .clock_in(clk), .reset_n_in(reset_n_in),
    .op_code_in(op_code_in), .op_code_valid_in(op_code_valid_in),
    .operand_in(operand_in), .operand_valid_in(operand_valid_in),
    .operand_count_in(operand_count_in),
    .response_out(response_out), .response_valid_out(response_valid_out),
    .start_capture_out(start_capture_out),
    .half_resolution_out(half_resolution_out),
    .compression_factor_out(compression_factor_out),
    .power_save_enable_out(power_save_enable_out),
    .image_ready_in(image_ready_in), .image_total_size_in(image_total_size_in),
    .image_data_in(image_data_in), .image_address_out(image_address_out),
    .metering_in(metering_in)
  );

  always #5 clk = ~clk;

  // Image buffer: three bytes, reads past the end return the final byte,
  // data appears RL clocks after the address.
  logic [7:0] mem [0:2];
  logic [7:0] pipe1 = '0, pipe2 = '0;
  function automatic logic [7:0] buf_byte(input logic [15:0] a);
    if (a == 16'd0) return mem[0];
    if (a == 16'd1) return mem[1];
    return mem[2];
  endfunction
  always @(posedge clk) begin
    pipe1 <= buf_byte(image_address_out);
    pipe2 <= pipe1;
  end
  assign image_data_in = pipe2;

  // Behavioural model of the register block
  bit          m_busy, m_rej, m_pwr;
  logic [15:0] m_half, m_shadow, m_addr;
  logic [1:0]  m_comp;
  logic [7:0]  cur_op;
  bit          mon_en = 0;
  bit          done = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected {valid, byte} for the opcode currently presented.
  function automatic logic [8:0] model_resp();
    logic [15:0] rem;
    int c;
    c = int'(operand_count_in);
    case (op_code_in)
      8'h21: begin
        rem = (image_total_size_in > m_addr) ? image_total_size_in - m_addr : 16'd0;
        if (c < 2) return {1'b1, 8'((rem >> (8 * (1 - c))) & 16'hFF)};
        return {1'b1, 8'h00};
      end
      8'h22: return {1'b1, buf_byte(m_addr)};
      8'h25: return (c < MC) ? {1'b1, 8'((metering_in >> (8 * c)) & 24'hFF)} : 9'h100;
      8'h27: return {1'b1, 5'b0, m_rej, m_busy, image_ready_in};
      default: return 9'h000;
    endcase
  endfunction

  function automatic logic [15:0] clampz(input logic [15:0] s);
    logic [15:0] v;
    v = s & 16'h03FF;
    if (v < 16'd100) return 16'd100;
    if (v > 16'd720) return 16'd720;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 0;
    reset_n_in = 1'b0;
    op_code_valid_in = 1'b0;
    operand_valid_in = 1'b0;
    tick(3);
    reset_n_in = 1'b1;
    tick(2);
    m_busy = 0; m_rej = 0; m_pwr = 0; m_comp = '0;
    m_half = 16'd360; m_shadow = 16'd360; m_addr = '0;
    mon_en = 1;
    tick(2);
  endtask

  task automatic begin_txn(input logic [7:0] op, output int pulses);
    mon_en = 0;
    cur_op = op;
    op_code_in = op;
    op_code_valid_in = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (start_capture_out) pulses++;
    end
    tick(1);
    if (op == 8'h20) begin
      if (!m_busy) begin m_busy = 1; m_addr = '0; end
      else m_rej = 1;
    end
    if (op != 8'h22) begin
      mon_en = 1;
      tick(2);
    end
  endtask

  task automatic end_txn();
    mon_en = 0;
    op_code_valid_in = 1'b0;
    tick(4);
    if (cur_op == 8'h23) m_half = clampz(m_shadow);
    if (cur_op == 8'h27) m_rej = 0;
    mon_en = 1;
    tick(2);
  endtask

  task automatic strobe(input logic [7:0] cnt, input logic [7:0] b);
    mon_en = 0;
    operand_count_in = cnt;
    operand_in = b;
    operand_valid_in = 1'b1;
    tick(2);
    operand_valid_in = 1'b0;
    tick(3);
    if (cur_op == 8'h23 && cnt == 8'd0) m_shadow[15:8] = b;
    if (cur_op == 8'h23 && cnt == 8'd1) m_shadow[7:0] = b;
    if (cur_op == 8'h26) m_comp = b[1:0];
    if (cur_op == 8'h28) m_pwr = b[0];
    mon_en = 1;
    tick(2);
  endtask

  task automatic set_count(input logic [7:0] cnt);
    mon_en = 0;
    operand_count_in = cnt;
    tick(3);
    mon_en = 1;
  endtask

  task automatic set_ready(input logic v);
    mon_en = 0;
    if (v && !image_ready_in) m_busy = 0;
    image_ready_in = v;
    tick(3);
    mon_en = 1;
    tick(2);
  endtask

  task automatic wait_stream(input logic [7:0] exp_b);
    bit seen;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (response_valid_out) seen = 1;
    end
    tick(1);
    check("stream_reached", 32'(seen), 32'd1);
    check("first_byte", 32'(response_out), 32'(exp_b));
    mon_en = 1;
    tick(2);
  endtask

  task automatic read_strobe(input logic [7:0] exp_b, input logic [15:0] exp_addr);
    bit refetch, fin;
    int lows;
    mon_en = 0;
    refetch = (m_addr < image_total_size_in);
    operand_valid_in = 1'b1;
    lows = 0;
    fin = 0;
    for (int i = 0; i < 25 && !fin; i++) begin
      @(negedge clk);
      if (!response_valid_out) lows++;
      else if (lows > 0 || (!refetch && i >= 6)) fin = 1;
      @(posedge clk);
      #1;
      if (i == 1) operand_valid_in = 1'b0;
    end
    operand_valid_in = 1'b0;
    check("strobe_done", 32'(fin), 32'd1);
    if (refetch) begin
      check("prefetch_gap", 32'(lows >= RL), 32'd1);
      m_addr = m_addr + 16'd1;
    end else begin
      check("hold_no_gap", 32'(lows), 32'd0);
    end
    check("read_byte", 32'(response_out), 32'(exp_b));
    check("read_addr", 32'(image_address_out), 32'(exp_addr));
    mon_en = 1;
    tick(2);
  endtask

  // Per-cycle comparison of the DUT against the model.
  task automatic monitor_loop();
    logic [8:0] e;
    while (!done) begin
      @(negedge clk);
      if (mon_en && reset_n_in) begin
        check("mon_half_res", 32'(half_resolution_out), 32'(m_half));
        check("mon_compression", 32'(compression_factor_out), 32'(m_comp));
        check("mon_power_save", 32'(power_save_enable_out), 32'(m_pwr));
        check("mon_address", 32'(image_address_out), 32'(m_addr));
        check("mon_no_capture", 32'(start_capture_out), 32'd0);
        if (!op_code_valid_in) begin
          check("mon_rsp_valid_idle", 32'(response_valid_out), 32'd0);
        end else begin
          e = model_resp();
          check("mon_rsp_valid", 32'(response_valid_out), 32'(e[8]));
          if (e[8]) check("mon_rsp_data", 32'(response_out), 32'(e[7:0]));
        end
      end
    end
  endtask

  task automatic main_seq();
    int p;
    mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3;

    do_reset();
    check("rst_response", 32'(response_out), 32'h00);
    check("rst_rsp_valid", 32'(response_valid_out), 32'd0);
    check("rst_half_res", 32'(half_resolution_out), 32'd360);
    check("rst_address", 32'(image_address_out), 32'd0);

    // Status / capture / busy lock
    begin_txn(8'h27, p);
    check("status_after_reset", 32'(response_out), 32'h00);
    end_txn();
    begin_txn(8'h20, p);
    check("capture_pulses", 32'(p), 32'd1);
    end_txn();
    begin_txn(8'h27, p);
    check("status_busy", 32'(response_out), 32'h02);
    end_txn();
    begin_txn(8'h20, p);
    check("capture_rejected_pulses", 32'(p), 32'd0);
    end_txn();
    begin_txn(8'h27, p);
    check("status_rejected", 32'(response_out), 32'h06);
    end_txn();
    set_ready(1'b1);
    begin_txn(8'h27, p);
    check("status_ready", 32'(response_out), 32'h01);
    end_txn();
    set_ready(1'b0);

    // Prefetched streaming with end-of-image hold
    image_total_size_in = 16'd3;
    begin_txn(8'h22, p);
    wait_stream(8'hA1);
    read_strobe(8'hB2, 16'd1);
    read_strobe(8'hC3, 16'd2);
    read_strobe(8'hC3, 16'd3);
    read_strobe(8'hC3, 16'd3);
    read_strobe(8'hC3, 16'd3);
    end_txn();
    check("address_retained", 32'(image_address_out), 32'd3);

    // Bytes available
    do_reset();
    begin_txn(8'h22, p);
    wait_stream(8'hA1);
    read_strobe(8'hB2, 16'd1);
    end_txn();
    image_total_size_in = 16'h0203;
    begin_txn(8'h21, p);
    set_count(8'd0); check("avail_b0", 32'(response_out), 32'h02);
    set_count(8'd1); check("avail_b1", 32'(response_out), 32'h02);
    set_count(8'd2); check("avail_b2", 32'(response_out), 32'h00);
    end_txn();
    image_total_size_in = 16'd0;
    begin_txn(8'h21, p);
    set_count(8'd0); check("avail_sat_b0", 32'(response_out), 32'h00);
    set_count(8'd1); check("avail_sat_b1", 32'(response_out), 32'h00);
    end_txn();
    image_total_size_in = 16'd3;

    // Zoom shadow and clamped commit
    begin_txn(8'h23, p);
    strobe(8'd0, 8'h01);
    strobe(8'd1, 8'h2C);
    check("zoom_not_yet", 32'(half_resolution_out), 32'd360);
    end_txn();
    check("zoom_300", 32'(half_resolution_out), 32'd300);
    begin_txn(8'h23, p); strobe(8'd0, 8'h03); strobe(8'd1, 8'hFF); end_txn();
    check("zoom_clamp_hi", 32'(half_resolution_out), 32'd720);
    begin_txn(8'h23, p); strobe(8'd0, 8'h00); strobe(8'd1, 8'h10); end_txn();
    check("zoom_clamp_lo", 32'(half_resolution_out), 32'd100);
    begin_txn(8'h23, p); strobe(8'd0, 8'h02); end_txn();
    check("zoom_single_byte", 32'(half_resolution_out), 32'd528);

    // Metering
    begin_txn(8'h25, p);
    set_count(8'd0); check("meter_ch0", 32'(response_out), 32'h11);
    set_count(8'd1); check("meter_ch1", 32'(response_out), 32'h22);
    set_count(8'd2); check("meter_ch2", 32'(response_out), 32'h33);
    set_count(8'd3); check("meter_ch3", 32'(response_out), 32'h00);
    set_count(8'd4); check("meter_ch4", 32'(response_out), 32'h00);
    end_txn();

    // Compression, power save, unknown opcode
    begin_txn(8'h26, p); strobe(8'd0, 8'hFE); end_txn();
    check("compression", 32'(compression_factor_out), 32'd2);
    begin_txn(8'h28, p); strobe(8'd0, 8'h01); end_txn();
    check("power_save", 32'(power_save_enable_out), 32'd1);
    begin_txn(8'h24, p); strobe(8'd0, 8'h03); end_txn();
    check("unknown_no_change", 32'(compression_factor_out), 32'd2);

    // Reset in the middle of a zoom transaction discards the shadow
    begin_txn(8'h23, p);
    strobe(8'd0, 8'h01);
    strobe(8'd1, 8'hF4);
    do_reset();
    check("reset_mid_zoom", 32'(half_resolution_out), 32'd360);
    begin_txn(8'h23, p); end_txn();
    check("shadow_discarded", 32'(half_resolution_out), 32'd360);

    done = 1;
  endtask

  initial begin
    fork
      main_seq();
      monitor_loop();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
